cold_buffer_seq: RTL and testbench

//  Sequencer for the 128-row x 256-word cold buffer (read/write/idx port). Loads a tile of
//  cfg_rows rows from the DMA fill stream. Then replays those rows cfg_passes times to the
//  MLU array through a valid/ready stream. Drives buffer idx/read_en/write_en only; data

---
 rtl/pudiannao_pkg.sv | 25 ++
 rtl/cb_row_pass_cnt.sv | 58 +++++
 rtl/cold_buffer_seq.sv | 187 ++++++++++++++++++
 tb/tb_cold_buffer_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pudiannao_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pudiannao_pkg
//  Brief    : Shared constants and state encoding for the cold-buffer
//             sequencer and its helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package pudiannao_pkg;

    // Cold buffer geometry: 128 rows of 256 words each.
    localparam int CB_ROWS   = 128;
    localparam int CB_IDX_W  = 7;
    localparam int CB_WORDS  = 256;
    localparam int CB_PASS_W = 8;

    // Sequencer states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        CB_IDLE   = 2'd0,
        CB_FILL   = 2'd1,
        CB_STREAM = 2'd2,
        CB_DONE   = 2'd3
    } cb_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/cb_row_pass_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : cb_row_pass_cnt
//  Brief    : Row counter with programmable wrap point plus a pass counter.
//             o_term flags the last row of the last pass, so the owner can
//             finish on the same increment that consumes it.
//  Revision : 1.0 - initial release
// ============================================================================
module cb_row_pass_cnt
    import pudiannao_pkg::*;
#(
    parameter int IDX_W  = CB_IDX_W,
    parameter int PASS_W = CB_PASS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [IDX_W:0]    i_wrap_rows,
    input  logic [PASS_W-1:0] i_passes,
    output logic [IDX_W-1:0]  o_row,
    output logic              o_term
);

    logic [IDX_W-1:0]  r_row;
    logic [PASS_W-1:0] r_pass;
    logic [IDX_W:0]    w_row_max;
    logic [PASS_W-1:0] w_pass_max;
    logic              w_row_last;

    // Row count is held one-extended so a full 2**IDX_W row tile still fits.
    assign w_row_max  = i_wrap_rows - (IDX_W+1)'(1);
    assign w_pass_max = i_passes - PASS_W'(1);
    assign w_row_last = ({1'b0, r_row} == w_row_max);

    assign o_row  = r_row;
    assign o_term = w_row_last && (r_pass == w_pass_max);

    // Advance row; on wrap return to row 0 and bump the pass count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row  <= '0;
            r_pass <= '0;
        end else if (i_clr) begin
            r_row  <= '0;
            r_pass <= '0;
        end else if (i_inc) begin
            if (w_row_last) begin
                r_row  <= '0;
                r_pass <= r_pass + PASS_W'(1);
            end else begin
                r_row  <= r_row + IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cold_buffer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cold_buffer_seq
//  Brief    : Cold-buffer sequencer. Loads a tile of rows from the DMA fill
//             stream, then replays it a programmable number of passes to the
//             MLU over a valid/ready stream. Drives only the buffer index and
//             read/write strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module cold_buffer_seq
    import pudiannao_pkg::*;
#(
    parameter int ROWS   = CB_ROWS,
    parameter int IDX_W  = CB_IDX_W,
    parameter int PASS_W = CB_PASS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [7:0]        cfg_rows,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              fill_valid,
    output logic              fill_ready,
    output logic [IDX_W-1:0]  buf_idx,
    output logic              buf_wr_en,
    output logic              buf_rd_en,
    output logic              strm_valid,
    input  logic              strm_ready,
    output logic [IDX_W-1:0]  strm_row,
    output logic              strm_last,
    output logic              busy,
    output logic              done
);

    cb_seq_state_t     r_state;
    cb_seq_state_t     w_state_next;

    logic [IDX_W:0]    r_rows;
    logic [PASS_W-1:0] r_passes;
    logic              r_rd_done;
    logic              r_strm_valid;
    logic [IDX_W-1:0]  r_strm_row;
    logic              r_strm_last;

    logic [IDX_W:0]    w_rows_clamp;
    logic              w_start;
    logic              w_wr_acc;
    logic              w_rd_issue;
    logic              w_consume;
    logic [IDX_W-1:0]  w_wr_row;
    logic [IDX_W-1:0]  w_rd_row;
    logic              w_wr_term;
    logic              w_rd_term;

    // Oversized tiles clamp to the buffer depth.
    assign w_rows_clamp = (int'(cfg_rows) > ROWS) ? (IDX_W+1)'(ROWS)
                                                  : (IDX_W+1)'(cfg_rows);

    assign w_start   = (r_state == CB_IDLE) && cfg_start;
    assign w_wr_acc  = (r_state == CB_FILL) && fill_valid;
    assign w_consume = r_strm_valid && strm_ready;
    // A read may issue when the output slot is empty or being drained now.
    assign w_rd_issue = (r_state == CB_STREAM) && !r_rd_done
                        && (!r_strm_valid || strm_ready);

    assign buf_wr_en  = w_wr_acc;
    assign buf_rd_en  = w_rd_issue;
    assign strm_valid = r_strm_valid;
    assign strm_row   = r_strm_row;
    assign strm_last  = r_strm_last;
    assign busy       = (r_state != CB_IDLE);
    assign done       = (r_state == CB_DONE);

    // Write side only ever makes a single pass over the tile.
    cb_row_pass_cnt #(
        .IDX_W  (IDX_W),
        .PASS_W (PASS_W)
    ) u_wr_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start),
        .i_inc       (w_wr_acc),
        .i_wrap_rows (r_rows),
        .i_passes    (PASS_W'(1)),
        .o_row       (w_wr_row),
        .o_term      (w_wr_term)
    );

    cb_row_pass_cnt #(
        .IDX_W  (IDX_W),
        .PASS_W (PASS_W)
    ) u_rd_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start),
        .i_inc       (w_rd_issue),
        .i_wrap_rows (r_rows),
        .i_passes    (r_passes),
        .o_row       (w_rd_row),
        .o_term      (w_rd_term)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus fill handshake and buffer index steering.
    always_comb begin
        w_state_next = r_state;
        fill_ready   = 1'b0;
        buf_idx      = '0;
        case (r_state)
            CB_IDLE: begin
                if (cfg_start) begin
                    w_state_next = (w_rows_clamp == '0) ? CB_DONE : CB_FILL;
                end
            end
            CB_FILL: begin
                fill_ready = 1'b1;
                buf_idx    = w_wr_row;
                if (fill_valid && w_wr_term) begin
                    w_state_next = (r_passes == '0) ? CB_DONE : CB_STREAM;
                end
            end
            CB_STREAM: begin
                buf_idx = w_rd_row;
                if (w_consume && r_strm_last) begin
                    w_state_next = CB_DONE;
                end
            end
            CB_DONE: begin
                w_state_next = CB_IDLE;
            end
            default: begin
                w_state_next = CB_IDLE;
            end
        endcase
    end

    // Tile configuration is captured at start and held until the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rows   <= '0;
            r_passes <= '0;
        end else if (w_start) begin
            r_rows   <= w_rows_clamp;
            r_passes <= cfg_passes;
        end
    end

    // Sticky flag once the final read of the final pass has issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_done <= 1'b0;
        end else if (w_start) begin
            r_rd_done <= 1'b0;
        end else if (w_rd_issue && w_rd_term) begin
            r_rd_done <= 1'b1;
        end
    end

    // Output slot: row tag and last flag travel with the read that fills it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_strm_valid <= 1'b0;
            r_strm_row   <= '0;
            r_strm_last  <= 1'b0;
        end else if (w_start) begin
            r_strm_valid <= 1'b0;
            r_strm_row   <= '0;
            r_strm_last  <= 1'b0;
        end else if (w_rd_issue) begin
            r_strm_valid <= 1'b1;
            r_strm_row   <= w_rd_row;
            r_strm_last  <= w_rd_term;
        end else if (w_consume) begin
            r_strm_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cold_buffer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cold_buffer_seq
//  Brief    : Directed self-checking bench for cold_buffer_seq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cold_buffer_seq;

    localparam int IDX_W  = 7;
    localparam int PASS_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_start = 1'b0;
    logic [7:0]        cfg_rows = '0;
    logic [PASS_W-1:0] cfg_passes = '0;
    logic              fill_valid = 1'b0;
    logic              fill_ready;
    logic [IDX_W-1:0]  buf_idx;
    logic              buf_wr_en;
    logic              buf_rd_en;
    logic              strm_valid;
    logic              strm_ready = 1'b0;
    logic [IDX_W-1:0]  strm_row;
    logic              strm_last;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    int nwr, nrd, ncons, idx_err;
    bit got_done;
    int cons_row  [0:255];
    int cons_last [0:255];

    cold_buffer_seq #(
        .ROWS   (128),
        .IDX_W  (IDX_W),
        .PASS_W (PASS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_rows   (cfg_rows),
        .cfg_passes (cfg_passes),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .buf_idx    (buf_idx),
        .buf_wr_en  (buf_wr_en),
        .buf_rd_en  (buf_rd_en),
        .strm_valid (strm_valid),
        .strm_ready (strm_ready),
        .strm_row   (strm_row),
        .strm_last  (strm_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: end of test not reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int r, input int p);
        cfg_rows   = 8'(r);
        cfg_passes = PASS_W'(p);
        cfg_start  = 1'b1;
        @(negedge clk);
        cyc();
        cfg_start  = 1'b0;
    endtask

    task automatic clear_counts();
        nwr = 0; nrd = 0; ncons = 0; idx_err = 0; got_done = 1'b0;
    endtask

    // Runs until done is seen (or bound cycles), tallying strobes and
    // recording every consumed row; returns in the cycle after done.
    task automatic run_tile(input int rows, input int bound);
        for (int c = 0; c < bound && !got_done; c++) begin
            @(negedge clk);
            if (buf_wr_en) begin
                if (int'(buf_idx) != nwr) idx_err++;
                nwr++;
            end
            if (buf_rd_en) begin
                if (rows == 0 || int'(buf_idx) != (nrd % rows)) idx_err++;
                nrd++;
            end
            if (buf_wr_en && buf_rd_en) idx_err++;
            if (strm_valid && strm_ready && ncons < 256) begin
                cons_row[ncons]  = int'(strm_row);
                cons_last[ncons] = int'(strm_last);
                ncons++;
            end
            if (done) got_done = 1'b1;
            cyc();
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {done, fill_ready, buf_wr_en, buf_rd_en, strm_valid, strm_last, buf_idx, strm_row}, 0);
        rst = 1'b1;
        cyc();

        // ---------------- 1: rows=4 passes=1 ----------------
        fill_valid = 1'b1;
        strm_ready = 1'b1;
        cfg_rows = 8'd4; cfg_passes = 8'd1; cfg_start = 1'b1;
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ready", fill_ready, 0);
        cyc();
        cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_fill_ready", fill_ready, 1);
            chk("t1_fill_wr", buf_wr_en, 1);
            chk("t1_fill_idx", buf_idx, i);
            chk("t1_fill_rd", buf_rd_en, 0);
            cyc();
        end
        fill_valid = 1'b0;
        @(negedge clk);
        chk("t1_s0_rd", buf_rd_en, 1);
        chk("t1_s0_idx", buf_idx, 0);
        chk("t1_s0_valid", strm_valid, 0);
        chk("t1_s0_ready", fill_ready, 0);
        cyc();
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("t1_s_rd", buf_rd_en, 1);
            chk("t1_s_idx", buf_idx, i);
            chk("t1_s_valid", strm_valid, 1);
            chk("t1_s_row", strm_row, i - 1);
            chk("t1_s_last", strm_last, 0);
            cyc();
        end
        @(negedge clk);
        chk("t1_tail_rd", buf_rd_en, 0);
        chk("t1_tail_row", strm_row, 3);
        chk("t1_tail_last", strm_last, 1);
        chk("t1_tail_done", done, 0);
        cyc();
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_done_valid", strm_valid, 0);
        cyc();
        @(negedge clk);
        chk("t1_after_done", done, 0);
        chk("t1_after_busy", busy, 0);
        cyc();

        // ---------------- 2: rows=3 passes=2 ----------------
        fill_valid = 1'b1;
        strm_ready = 1'b1;
        start_tile(3, 2);
        clear_counts();
        run_tile(3, 40);
        fill_valid = 1'b0;
        chk("t2_done", got_done, 1);
        chk("t2_nwr", nwr, 3);
        chk("t2_nrd", nrd, 6);
        chk("t2_ncons", ncons, 6);
        chk("t2_idx", idx_err, 0);
        for (int k = 0; k < 6; k++) begin
            chk("t2_row", cons_row[k], k % 3);
            chk("t2_last", cons_last[k], (k == 5) ? 1 : 0);
        end

        // ---------------- 3: stall on row 0 ----------------
        fill_valid = 1'b1;
        start_tile(2, 1);
        repeat (2) begin
            @(negedge clk);
            cyc();
        end
        fill_valid = 1'b0;
        strm_ready = 1'b0;
        @(negedge clk);
        chk("t3_s0_rd", buf_rd_en, 1);
        chk("t3_s0_idx", buf_idx, 0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_valid", strm_valid, 1);
            chk("t3_stall_row", strm_row, 0);
            chk("t3_stall_rd", buf_rd_en, 0);
            cyc();
        end
        strm_ready = 1'b1;
        @(negedge clk);
        chk("t3_rel_rd", buf_rd_en, 1);
        chk("t3_rel_idx", buf_idx, 1);
        chk("t3_rel_row", strm_row, 0);
        cyc();
        @(negedge clk);
        chk("t3_row1", strm_row, 1);
        chk("t3_row1_last", strm_last, 1);
        chk("t3_row1_valid", strm_valid, 1);
        cyc();
        @(negedge clk);
        chk("t3_done", done, 1);
        cyc();

        // ---------------- 4a: rows=0 ----------------
        start_tile(0, 3);
        @(negedge clk);
        chk("t4a_done", done, 1);
        chk("t4a_strobes", {fill_ready, buf_wr_en, buf_rd_en}, 0);
        cyc();
        @(negedge clk);
        chk("t4a_idle", {busy, done}, 0);
        cyc();

        // ---------------- 4b: rows=200 clamps to 128 ----------------
        fill_valid = 1'b1;
        strm_ready = 1'b1;
        start_tile(200, 1);
        clear_counts();
        run_tile(128, 400);
        fill_valid = 1'b0;
        chk("t4b_done", got_done, 1);
        chk("t4b_nwr", nwr, 128);
        chk("t4b_nrd", nrd, 128);
        chk("t4b_ncons", ncons, 128);
        chk("t4b_idx", idx_err, 0);
        chk("t4b_row127", cons_row[127], 127);
        chk("t4b_last127", cons_last[127], 1);
        chk("t4b_last126", cons_last[126], 0);

        // ---------------- 5: passes=0, start ignored mid-fill ----------------
        fill_valid = 1'b1;
        start_tile(5, 0);
        @(negedge clk);
        chk("t5_wr0", buf_wr_en, 1);
        cyc();
        @(negedge clk);
        cyc();
        cfg_start = 1'b1; cfg_rows = 8'd9; cfg_passes = 8'd3;
        @(negedge clk);
        chk("t5_wr_idx2", buf_idx, 2);
        cyc();
        cfg_start = 1'b0;
        clear_counts();
        nwr = 3;
        run_tile(5, 30);
        fill_valid = 1'b0;
        chk("t5_done", got_done, 1);
        chk("t5_nwr", nwr, 5);
        chk("t5_nrd", nrd, 0);
        chk("t5_idx", idx_err, 0);
        @(negedge clk);
        chk("t5_idle", busy, 0);
        cyc();

        // ---------------- 6: async reset mid-stream ----------------
        fill_valid = 1'b1;
        strm_ready = 1'b1;
        start_tile(4, 2);
        repeat (4) begin
            @(negedge clk);
            cyc();
        end
        fill_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cyc();
        end
        chk("t6_pre_valid", strm_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", strm_valid, 0);
        chk("t6_rst_outs", {done, fill_ready, buf_wr_en, buf_rd_en, strm_last, buf_idx, strm_row}, 0);
        cyc();
        rst = 1'b1;
        cyc();
        fill_valid = 1'b1;
        start_tile(1, 1);
        clear_counts();
        run_tile(1, 20);
        fill_valid = 1'b0;
        chk("t6_done", got_done, 1);
        chk("t6_nwr", nwr, 1);
        chk("t6_nrd", nrd, 1);
        chk("t6_ncons", ncons, 1);
        chk("t6_last", cons_last[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
